// File: rtl/alu_stage_pkg.sv
// Shared definitions for the ALU execute stage: opcode/funct3 encodings,
// the CDB result record and a branch-condition helper.
package alu_stage_pkg;

    localparam int ROB_W = 5;
    localparam int XLEN  = 32;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // Integer funct3 encodings
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [ROB_W-1:0] rob_id;
        logic [XLEN-1:0]  value;
    } alu_result_t;

    localparam int RESULT_W = $bits(alu_result_t);

    // Reserved encodings (010/011) report not-taken.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
        logic taken;
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) <  $signed(b));
            F3_BGE:  taken = ($signed(a) >= $signed(b));
            F3_BLTU: taken = (a <  b);
            F3_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO between the execute register and the ALU CDB channel.
// Head entry is presented combinationally; i_en low freezes all state.
module alu_result_fifo
    import alu_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_srst,
    input  logic                   i_clear,
    input  logic                   i_en,
    input  logic                   i_push,
    input  alu_result_t            i_data,
    input  logic                   i_pop,
    output alu_result_t            o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    alu_result_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Upstream occupancy accounting guarantees no push while full.
    assign w_push = i_en && i_push;
    assign w_pop  = i_en && i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_srst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage is zeroed only on reset so the idle CDB value reads 0.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/alu_stage.sv
// ALU execute stage: combinational integer/branch compute captured in s1,
// buffered in a result FIFO and broadcast on the ALU CDB channel.
module alu_stage
    import alu_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _alu_ready,
    input  logic [4:0]  _alu_rob_id,
    input  logic [6:0]  _alu_type,
    input  logic [3:0]  _alu_op,
    input  logic [31:0] _alu_v1,
    input  logic [31:0] _alu_v2,
    output logic        _alu_full,
    input  logic        _cdb_stall,
    output logic        _cdb_ready,
    output logic [4:0]  _cdb_rob_id,
    output logic [31:0] _cdb_value
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              r_s1_valid;
    alu_result_t       r_s1_data;

    logic [XLEN-1:0]   w_result;
    logic [4:0]        w_shamt;
    logic [2:0]        w_f3;
    logic              w_accept;
    alu_result_t       w_head;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_occupancy;
    logic              w_empty;

    assign w_f3    = _alu_op[2:0];
    assign w_shamt = _alu_v2[4:0];

    always_comb begin
        w_result = _alu_v1 + _alu_v2;
        if (_alu_type == OP_R || _alu_type == OP_I) begin
            case (w_f3)
                // Immediate adds never subtract, whatever op[3] carries.
                F3_ADD:  w_result = (_alu_type == OP_R && _alu_op[3]) ?
                                    (_alu_v1 - _alu_v2) : (_alu_v1 + _alu_v2);
                F3_SLL:  w_result = _alu_v1 << w_shamt;
                F3_SLT:  w_result = {31'b0, $signed(_alu_v1) < $signed(_alu_v2)};
                F3_SLTU: w_result = {31'b0, _alu_v1 < _alu_v2};
                F3_XOR:  w_result = _alu_v1 ^ _alu_v2;
                F3_SR:   w_result = _alu_op[3] ? 32'($signed(_alu_v1) >>> w_shamt) :
                                                 (_alu_v1 >> w_shamt);
                F3_OR:   w_result = _alu_v1 | _alu_v2;
                F3_AND:  w_result = _alu_v1 & _alu_v2;
                default: w_result = _alu_v1 + _alu_v2;
            endcase
        end else if (_alu_type == OP_BR) begin
            w_result = {31'b0, branch_taken(w_f3, _alu_v1, _alu_v2)};
        end
    end

    // A flush discards whatever is being issued alongside it.
    assign w_accept = _alu_ready && !_alu_full && rdy_in && !_clear;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (_clear) begin
            r_s1_valid <= 1'b0;
        end else if (rdy_in) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data.rob_id <= _alu_rob_id;
                r_s1_data.value  <= w_result;
            end
        end
    end

    alu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk_in),
        .i_srst  (rst_in),
        .i_clear (_clear),
        .i_en    (rdy_in),
        .i_push  (r_s1_valid),
        .i_data  (r_s1_data),
        .i_pop   (!_cdb_stall),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // s1 counts toward occupancy so an accepted result always has a slot.
    assign w_occupancy = w_count + CNT_W'(r_s1_valid);
    assign _alu_full   = (w_occupancy >= CNT_W'(DEPTH));

    assign _cdb_ready  = !w_empty;
    assign _cdb_rob_id = w_head.rob_id;
    assign _cdb_value  = w_head.value;

endmodule

// File: tb/tb_alu_stage.sv
// Scoreboard bench for alu_stage: stimulus pushes hand-computed results,
// a negedge monitor pops and compares each CDB broadcast.
module tb_alu_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _alu_ready;
    logic [4:0]  _alu_rob_id;
    logic [6:0]  _alu_type;
    logic [3:0]  _alu_op;
    logic [31:0] _alu_v1;
    logic [31:0] _alu_v2;
    logic        _alu_full;
    logic        _cdb_stall;
    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;

    typedef struct {
        logic [4:0]  rob;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BR  = 7'b1100011;
    localparam logic [6:0] T_LUI = 7'b0110111;

    alu_stage #(.DEPTH(4)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        ._clear      (_clear),
        ._alu_ready  (_alu_ready),
        ._alu_rob_id (_alu_rob_id),
        ._alu_type   (_alu_type),
        ._alu_op     (_alu_op),
        ._alu_v1     (_alu_v1),
        ._alu_v2     (_alu_v2),
        ._alu_full   (_alu_full),
        ._cdb_stall  (_cdb_stall),
        ._cdb_ready  (_cdb_ready),
        ._cdb_rob_id (_cdb_rob_id),
        ._cdb_value  (_cdb_value)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: every accepted broadcast is checked against the scoreboard head.
    always @(negedge clk_in) begin
        if (!rst_in && !_clear && _cdb_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL cdb_unexpected cyc=%0d got rob=%0d val=%h, required no broadcast",
                         cyc, _cdb_rob_id, _cdb_value);
            end else if (!_cdb_stall && rdy_in) begin
                exp_t e;
                e = sb.pop_front();
                n_tests++;
                if (_cdb_rob_id !== e.rob || _cdb_value !== e.val ||
                    (e.cyc >= 0 && cyc != e.cyc)) begin
                    n_fail++;
                    $display("[TB] FAIL cdb_result got rob=%0d val=%h cyc=%0d, required rob=%0d val=%h cyc=%0d",
                             _cdb_rob_id, _cdb_value, cyc, e.rob, e.val, e.cyc);
                end else begin
                    $display("[TB] cdb rob=%0d val=%h cyc=%0d", _cdb_rob_id, _cdb_value, cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got %h, required %h", name, cyc, got, want);
        end
    endtask

    // One clock cycle: drive inputs, then check _alu_full and log the issue.
    task automatic step(input logic v, input logic [4:0] rob, input logic [6:0] typ,
                        input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input logic stall, input logic rdy,
                        input logic clr, input logic exp_full, input int lat);
        @(posedge clk_in);
        #1;
        _alu_ready  = v;
        _alu_rob_id = rob;
        _alu_type   = typ;
        _alu_op     = op;
        _alu_v1     = a;
        _alu_v2     = b;
        _cdb_stall  = stall;
        rdy_in      = rdy;
        _clear      = clr;
        @(negedge clk_in);
        check("alu_full", {63'b0, _alu_full}, {63'b0, exp_full});
        if (clr) begin
            sb.delete();
        end else if (v && rdy && !exp_full) begin
            sb.push_back('{rob, expv, (lat < 0) ? -1 : cyc + lat});
            $display("[TB] issue rob=%0d type=%b op=%b v1=%h v2=%h exp=%h", rob, typ, op, a, b, expv);
        end
    endtask

    task automatic issue(input logic [4:0] rob, input logic [6:0] typ, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        step(1'b1, rob, typ, op, a, b, expv, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    endtask

    task automatic idle(input logic stall, input logic rdy, input logic exp_full);
        step(1'b0, 5'd0, 7'd0, 4'd0, 32'd0, 32'd0, 32'd0, stall, rdy, 1'b0, exp_full, -1);
    endtask

    initial begin
        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        _clear      = 1'b0;
        _alu_ready  = 1'b0;
        _alu_rob_id = '0;
        _alu_type   = '0;
        _alu_op     = '0;
        _alu_v1     = '0;
        _alu_v2     = '0;
        _cdb_stall  = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Idle after reset: every output stays zero.
        for (int i = 0; i < 5; i++) begin
            idle(1'b0, 1'b1, 1'b0);
            check("reset_outputs", {24'b0, _alu_full, _cdb_ready, _cdb_rob_id, _cdb_value}, 64'd0);
        end

        // Single sub with nominal 2-cycle latency.
        issue(5'd3, T_R, 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE);
        repeat (3) idle(1'b0, 1'b1, 1'b0);

        // Back-to-back mixed operations; _alu_full must stay low throughout.
        issue(5'd4,  T_I,   4'b1101, 32'h8000_0000, 32'd4,          32'hF800_0000);
        issue(5'd5,  T_R,   4'b0011, 32'd1,          32'hFFFF_FFFF, 32'd1);
        issue(5'd6,  T_BR,  4'b0100, 32'hFFFF_FFFF, 32'd1,          32'd1);
        issue(5'd7,  T_BR,  4'b0111, 32'd1,          32'hFFFF_FFFF, 32'd0);
        issue(5'd8,  T_I,   4'b1000, 32'd10,         32'd3,          32'd13);
        issue(5'd9,  T_R,   4'b0101, 32'h8000_0000, 32'd4,          32'h0800_0000);
        issue(5'd10, T_R,   4'b0010, 32'hFFFF_FFFF, 32'd1,          32'd1);
        issue(5'd11, T_BR,  4'b0010, 32'd9,          32'd9,          32'd0);
        issue(5'd12, T_BR,  4'b0000, 32'd9,          32'd9,          32'd1);
        issue(5'd13, T_R,   4'b0001, 32'd1,          32'h0000_0023, 32'd8);
        issue(5'd14, T_LUI, 4'b0000, 32'd0,          32'h1234_5000, 32'h1234_5000);
        issue(5'd15, T_R,   4'b0000, 32'hFFFF_FFFF, 32'd2,          32'd1);
        issue(5'd16, T_R,   4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        repeat (4) idle(1'b0, 1'b1, 1'b0);

        // Stalled CDB: exactly four accepts, then full; drains in order.
        step(1'b1, 5'd20, T_LUI, 4'd0, 32'd0, 32'd100, 32'd100, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        step(1'b1, 5'd21, T_LUI, 4'd0, 32'd0, 32'd101, 32'd101, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        step(1'b1, 5'd22, T_LUI, 4'd0, 32'd0, 32'd102, 32'd102, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        step(1'b1, 5'd23, T_LUI, 4'd0, 32'd0, 32'd103, 32'd103, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        step(1'b1, 5'd24, T_LUI, 4'd0, 32'd0, 32'd104, 32'd104, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        idle(1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1, 1'b1);
        check("stall_head_hold", {27'b0, _cdb_ready, _cdb_rob_id, _cdb_value}, {27'b0, 1'b1, 5'd20, 32'd100});
        idle(1'b0, 1'b1, 1'b1);
        idle(1'b0, 1'b1, 1'b0);
        repeat (4) idle(1'b0, 1'b1, 1'b0);

        // Flush with two results in flight and a third being presented.
        issue(5'd25, T_R, 4'b0000, 32'd1, 32'd1, 32'd2);
        issue(5'd26, T_R, 4'b0000, 32'd2, 32'd2, 32'd4);
        step(1'b1, 5'd27, T_R, 4'b0000, 32'd3, 32'd3, 32'd6, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        idle(1'b0, 1'b1, 1'b0);
        check("clear_no_ready", {63'b0, _cdb_ready}, 64'd0);
        idle(1'b0, 1'b1, 1'b0);
        issue(5'd28, T_R, 4'b0100, 32'h0000_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF);
        repeat (3) idle(1'b0, 1'b1, 1'b0);

        // rdy_in low for three cycles while s1 holds a result.
        step(1'b1, 5'd29, T_R, 4'b1000, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        repeat (3) idle(1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b0, 1'b1, 1'b0);

        // Bounded drain of anything still expected.
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            idle(1'b0, 1'b1, 1'b0);
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_stage.md
# alu_stage

Execution stage directly downstream of the reservation station. It accepts one ready instruction per cycle from the station's issue port and computes the integer/branch result in a registered execute stage. Results are buffered in a small result FIFO and broadcast on the ALU CDB channel. The CDB channel feeds the reservation station, ROB and load/store buffer. `_alu_full` provides backpressure so the station never issues into a stage that cannot hold the result.

## Interface
Parameters:
- `DEPTH`, default 4: result FIFO entries; power of two, ≥2.

Ports:
- `clk_in` in 1: system clock, one clock domain.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: low pauses the stage. All state holds; outputs keep their values.
- `_clear` in 1: misprediction flush, synchronous; same effect as reset on valid state.
- `_alu_ready` in 1: issue valid from the reservation station.
- `_alu_rob_id` in 5: ROB tag of the issued instruction.
- `_alu_type` in 7: RISC-V opcode field.
- `_alu_op` in 4: [2:0] = funct3, [3] = funct7 bit 5.
- `_alu_v1` in 32: operand 1.
- `_alu_v2` in 32: operand 2. Holds rs2 for opcodes 0110011/1100011, otherwise the immediate.
- `_alu_full` out 1: stage cannot accept an issue this cycle.
- `_cdb_stall` in 1: CDB consumer not accepting; hold the broadcast.
- `_cdb_ready` out 1: result valid on CDB.
- `_cdb_rob_id` out 5: tag of the broadcast result.
- `_cdb_value` out 32: broadcast value.

## Operation
- Issue is accepted when `_alu_ready && !_alu_full && rdy_in`. The station guarantees `_alu_ready` implies `!_alu_full`.
- An issue asserted while `_alu_full` is high is a bench error and is ignored.
- Execute register (s1) holds {valid, rob_id, result}. The result is computed combinationally from the issue inputs and captured on the accepting edge.
- Opcode 0110011 (R-type), with op[2:0]:
  - 000 → add, or sub when op[3] = 1.
  - 001 → sll.
  - 010 → slt (signed).
  - 011 → sltu.
  - 100 → xor.
  - 101 → srl, or sra when op[3] = 1.
  - 110 → or.
  - 111 → and.
- Opcode 0010011 (I-type): same encoding as R-type, with two differences:
  - op[3] is ignored except for funct3 101 (srai).
  - funct3 000 is always add.
- Shift amount is v2[4:0] for all shifts.
- Opcode 1100011 (branch): result is 32'd1 if taken, else 32'd0.
  - 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
  - Encodings 010/011 give 0.
- Any other opcode: result = v1 + v2, modulo 2^32. This covers lui (v1 = 0) and auipc/jal link values supplied by upstream.
- All arithmetic is 32-bit wrap-around; no overflow flags.
- s1 moves into the FIFO on every edge where s1 is valid.
- The FIFO head drives the CDB: `_cdb_ready` = FIFO non-empty.
- The head is popped on an edge where `_cdb_ready && !_cdb_stall`.
- Push and pop on the same edge is legal: count is unchanged and order is preserved.
- Occupancy = FIFO count + s1.valid.
- `_alu_full` = (occupancy ≥ DEPTH). It is combinational from registers only and has no path from `_alu_ready`.
- Precedence: `rst_in` > `_clear` > `!rdy_in`.
  - `rst_in` or `_clear` empties s1 and the FIFO and zeroes the pointers.
  - Data payload registers need not be cleared on `_clear`.
- `_clear` discards an issue presented in the same cycle.

## Timing
- Reset values:
  - `_alu_full` = 0.
  - `_cdb_ready` = 0.
  - `_cdb_rob_id` = 0.
  - `_cdb_value` = 0 (FIFO storage zeroed on `rst_in`).
- Latency with an empty FIFO and no stall:
  - Issue sampled at end of cycle c.
  - s1 valid in c+1.
  - `_cdb_ready` high in c+2.
  - Popped at end of c+2.
- Throughput: one result per cycle sustained with `_cdb_stall` low; `_alu_full` never asserts.
- With `_cdb_stall` held high, the stage accepts exactly DEPTH issues. `_alu_full` rises in the cycle after the DEPTH-th accept.
- `_alu_full` falls the cycle after the first pop.
- `_cdb_rob_id`/`_cdb_value` are stable while `_cdb_ready && _cdb_stall`.
- FIFO pointers are log2(DEPTH) bits, with natural wrap.
- The count is log2(DEPTH)+1 bits.
- `rdy_in` low for k cycles adds exactly k cycles of latency; no result is lost or duplicated.

## Structure
- Shared package holds:
  - Opcode constants OP_R = 7'b0110011, OP_I = 7'b0010011, OP_BR = 7'b1100011.
  - funct3 constants.
  - Result record {rob_id[4:0], value[31:0]}.
- Sub-module `alu_result_fifo`: parameterised DEPTH × 37-bit FIFO with push/pop/clear, count, and an empty flag.
- Compute logic and s1 live in `alu_stage`.

## Test plan
- Reset, then idle: all outputs 0 for 5 cycles.
- Issue R-type sub, rob 3, v1 = 5, v2 = 7, op = 4'b1000 at cycle 0: `_cdb_ready` in cycle 2 with rob 3, value 32'hFFFFFFFE.
- Back-to-back issues over 4 cycles, stall low:
  - srai, v1 = 32'h80000000, v2 = 4, op = 4'b1101 → 32'hF8000000.
  - sltu 1 < 32'hFFFFFFFF → 1.
  - blt −1 < 1 → 1.
  - bgeu 1 ≥ 32'hFFFFFFFF → 0.
  - Expected: results in order on consecutive cycles, `_alu_full` never asserts.
- `_cdb_stall` high, issue 5 times with DEPTH = 4: fourth accept, then `_alu_full` = 1 next cycle. Drop stall: tags emerge in issue order; `_alu_full` low one cycle after the first pop.
- `_clear` in the cycle after 2 accepted issues, while a third is presented: no `_cdb_ready` afterwards; the next issue broadcasts with nominal 2-cycle latency.
- `rdy_in` low for 3 cycles while s1 is valid: broadcast delayed by exactly 3 cycles, with value unchanged.
